// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one unified fixed-latency memory port between
// instruction fetch (I, read-only) and LDUR/STUR data access (D).
//
// state | meaning
// IDLE  | no read outstanding; grants may be issued
// WAIT  | read outstanding; cnt counts down the memory latency
// RESP  | mem_rdata valid this cycle; captured into the owner's rdata
module mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic       PORT_I = 1'b0;
  localparam logic       PORT_D = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          last, last_nx;
  logic          owner, owner_nx;
  logic          i_rv_q, i_rv_nx, d_rv_q, d_rv_nx;
  logic [DW-1:0] i_rd_q, i_rd_nx, d_rd_q, d_rd_nx;
  state_t        read_state;

  // With MEM_LAT=1 the data arrives in the cycle right after the grant.
  assign read_state = (MEM_LAT == 1) ? RESP : WAIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= PORT_D;
      owner  <= PORT_I;
      i_rv_q <= 1'b0;
      d_rv_q <= 1'b0;
      i_rd_q <= '0;
      d_rd_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      last   <= last_nx;
      owner  <= owner_nx;
      i_rv_q <= i_rv_nx;
      d_rv_q <= d_rv_nx;
      i_rd_q <= i_rd_nx;
      d_rd_q <= d_rd_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    last_nx   = last;
    owner_nx  = owner;
    i_rv_nx   = 1'b0;
    d_rv_nx   = 1'b0;
    i_rd_nx   = i_rd_q;
    d_rd_nx   = d_rd_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (!rst) begin
          // I wins when alone or when D was served last.
          if (i_req && (!d_req || last == PORT_D)) begin
            i_gnt    = 1'b1;
            mem_en   = 1'b1;
            mem_addr = i_addr;
            last_nx  = PORT_I;
            owner_nx = PORT_I;
            cnt_nx   = LAT_M1;
            state_nx = read_state;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            last_nx   = PORT_D;
            if (!d_we) begin
              owner_nx = PORT_D;
              cnt_nx   = LAT_M1;
              state_nx = read_state;
            end
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
        if (owner == PORT_I) begin
          i_rd_nx = mem_rdata;
          i_rv_nx = 1'b1;
        end else begin
          d_rd_nx = mem_rdata;
          d_rv_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs are masked during reset so they read as idle at once.
  assign busy     = (state != IDLE) && !rst;
  assign i_rvalid = i_rv_q && !rst;
  assign d_rvalid = d_rv_q && !rst;
  assign i_rdata  = rst ? '0 : i_rd_q;
  assign d_rdata  = rst ? '0 : d_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2): fetch, tie, stores,
// alternation and reset during an outstanding read.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(64), .DW(64), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [10:0] exp_i, exp_d;

  initial begin
    // reset with requests active: everything must stay quiet
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 64'h40; d_addr = 64'h80; d_wdata = 64'h99; mem_rdata = 64'h1234;
    mid();
    chk("rst_i_gnt", i_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    nxt();
    mid();
    chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_gnt2", i_gnt | d_gnt, 0);
    nxt();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    nxt();

    // single fetch
    i_req = 1'b1; i_addr = 64'h40;
    mid();
    chk("f_i_gnt", i_gnt, 1); chk("f_mem_en", mem_en, 1);
    chk("f_mem_addr", mem_addr, 64'h40); chk("f_mem_we", mem_we, 0); chk("f_d_gnt", d_gnt, 0);
    nxt();
    i_req = 1'b0; i_addr = 0;
    mid();
    chk("f_busy1", busy, 1); chk("f_gnt1", i_gnt, 0); chk("f_mem_en1", mem_en, 0);
    nxt();
    mem_rdata = 64'hDEADBEEF;
    mid();
    chk("f_busy2", busy, 1); chk("f_rv2", i_rvalid, 0);
    nxt();
    mem_rdata = 0;
    mid();
    chk("f_rv3", i_rvalid, 1); chk("f_rdata3", i_rdata, 64'hDEADBEEF); chk("f_busy3", busy, 0);
    chk("f_d_rv3", d_rvalid, 0);
    nxt();
    mid();
    chk("f_rv4", i_rvalid, 0); chk("f_rdata_hold", i_rdata, 64'hDEADBEEF);
    nxt();

    // tie after reset: I first, D blocked until the I response cycle
    rst = 1'b1; nxt(); rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 64'h100; d_addr = 64'h200;
    mid();
    chk("t_i_gnt0", i_gnt, 1); chk("t_d_gnt0", d_gnt, 0); chk("t_addr0", mem_addr, 64'h100);
    nxt();
    i_req = 1'b0;
    mid();
    chk("t_d_gnt1", d_gnt, 0); chk("t_busy1", busy, 1);
    nxt();
    mem_rdata = 64'h1111;
    mid();
    chk("t_d_gnt2", d_gnt, 0);
    nxt();
    mem_rdata = 0;
    mid();
    chk("t_i_rv3", i_rvalid, 1); chk("t_i_rd3", i_rdata, 64'h1111);
    chk("t_d_gnt3", d_gnt, 1); chk("t_addr3", mem_addr, 64'h200); chk("t_we3", mem_we, 0);
    nxt();
    d_req = 1'b0;
    mid();
    chk("t_busy4", busy, 1); chk("t_i_rv4", i_rvalid, 0);
    nxt();
    mem_rdata = 64'h2222;
    mid();
    chk("t_d_rv5", d_rvalid, 0);
    nxt();
    mem_rdata = 0;
    mid();
    chk("t_d_rv6", d_rvalid, 1); chk("t_d_rd6", d_rdata, 64'h2222);
    chk("t_i_rd_hold", i_rdata, 64'h1111); chk("t_i_rv6", i_rvalid, 0);
    nxt();

    // back-to-back stores
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h10; d_wdata = 64'h55;
    mid();
    chk("s_gnt0", d_gnt, 1); chk("s_en0", mem_en, 1); chk("s_we0", mem_we, 1);
    chk("s_addr0", mem_addr, 64'h10); chk("s_wdata0", mem_wdata, 64'h55); chk("s_busy0", busy, 0);
    nxt();
    d_addr = 64'h18; d_wdata = 64'h66;
    mid();
    chk("s_gnt1", d_gnt, 1); chk("s_en1", mem_en, 1); chk("s_we1", mem_we, 1);
    chk("s_addr1", mem_addr, 64'h18); chk("s_wdata1", mem_wdata, 64'h66); chk("s_rv1", d_rvalid, 0);
    nxt();
    d_req = 1'b0; d_we = 1'b0; d_addr = 0; d_wdata = 0;
    mid();
    chk("s_rv2", d_rvalid, 0); chk("s_en2", mem_en, 0);
    chk("s_addr2", mem_addr, 0); chk("s_wdata2", mem_wdata, 0);
    nxt();
    mid();
    chk("s_rv3", d_rvalid, 0);
    nxt();

    // alternation: I reads, D writes, both requesting continuously; last=D
    exp_i = 11'b00100010001;
    exp_d = 11'b00010001000;
    i_req = 1'b1; i_addr = 64'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h400; d_wdata = 64'h77;
    for (int k = 0; k < 11; k++) begin
      mid();
      chk($sformatf("alt_i_gnt%0d", k), i_gnt, exp_i[k]);
      chk($sformatf("alt_d_gnt%0d", k), d_gnt, exp_d[k]);
      chk($sformatf("alt_we%0d", k), mem_we, exp_d[k]);
      chk($sformatf("alt_i_rv%0d", k), i_rvalid, exp_d[k]);
      nxt();
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    nxt(); nxt(); nxt();

    // reset during an outstanding read; last=I beforehand
    i_req = 1'b1; i_addr = 64'h500;
    mid();
    chk("r_i_gnt0", i_gnt, 1);
    nxt();
    i_req = 1'b0; rst = 1'b1;
    mid();
    chk("r_busy1", busy, 0); chk("r_rv1", i_rvalid, 0);
    nxt();
    rst = 1'b0; mem_rdata = 64'hBAD;
    mid();
    chk("r_busy2", busy, 0); chk("r_gnt2", i_gnt, 0);
    nxt();
    mem_rdata = 0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 64'h600; d_addr = 64'h700;
    mid();
    chk("r_i_rv3", i_rvalid, 0); chk("r_d_rv3", d_rvalid, 0); chk("r_i_rd3", i_rdata, 0);
    chk("r_tie_i", i_gnt, 1); chk("r_tie_d", d_gnt, 0); chk("r_tie_addr", mem_addr, 64'h600);
    nxt();
    i_req = 1'b0; d_req = 1'b0;
    nxt(); nxt(); nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
